// File: rtl/pellet_tracker.sv
// Pellet map, eat pipeline and BCD score for a Pac-Man maze of COLS x ROWS tiles.
// The map is refilled by a one-cell-per-cycle sweep and read by the renderer through an independent port.
module pellet_tracker #(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pac_x_i,
    input  logic [8:0]  pac_y_i,
    input  logic        pos_valid_i,
    input  logic        restart_i,
    input  logic [5:0]  rd_tx_i,
    input  logic [4:0]  rd_ty_i,
    output logic        rd_pellet_o,
    output logic [15:0] score_bcd_o,
    output logic [10:0] pellets_left_o,
    output logic        eat_pulse_o,
    output logic        busy_o,
    output logic        level_clear_o
);

    localparam int CELLS   = COLS * ROWS;
    localparam int AW      = $clog2(CELLS);
    localparam int PELLETS = (COLS - 2) * (ROWS - 2);

    localparam logic [5:0]    TX_LAST   = 6'(COLS - 1);
    localparam logic [4:0]    TY_LAST   = 5'(ROWS - 1);
    localparam logic [5:0]    TX_MAX    = 6'(COLS - 2);
    localparam logic [4:0]    TY_MAX    = 5'(ROWS - 2);
    localparam logic [AW-1:0] ADDR_LAST = AW'(CELLS - 1);

    // state    | meaning
    // ST_INIT  | sweeping the map, one cell per cycle
    // ST_RUN   | accepting positions, eating pellets
    // ST_CLEAR | every pellet eaten, waiting for restart
    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_CLEAR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] sw_addr_q, sw_addr_d;
    logic [5:0]    sw_tx_q, sw_tx_d;
    logic [4:0]    sw_ty_q, sw_ty_d;
    logic          s1_vld_q, s1_vld_d;
    logic [AW-1:0] s1_addr_q, s1_addr_d;
    logic          s2_vld_q, s2_vld_d;
    logic          s2_bit_q, s2_bit_d;
    logic [AW-1:0] s2_addr_q, s2_addr_d;
    logic [15:0]   score_q, score_d;
    logic [10:0]   left_q, left_d;
    logic          rd_q, rd_d;

    logic          mem_q [CELLS];
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic          mem_wd;

    logic [5:0]    eat_tx;
    logic [4:0]    eat_ty;
    logic [AW-1:0] eat_addr;
    logic [AW-1:0] rd_addr;
    logic          rd_ok;
    logic          accept;
    logic          eat_hit;
    logic          init_bit;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign eat_tx   = pac_x_i[9:4];
    assign eat_ty   = pac_y_i[8:4];
    assign eat_addr = AW'(eat_ty) * AW'(COLS) + AW'(eat_tx);
    assign rd_addr  = AW'(rd_ty_i) * AW'(COLS) + AW'(rd_tx_i);
    assign rd_ok    = (rd_tx_i <= TX_LAST) && (rd_ty_i <= TY_LAST);

    // Only one eat may be in flight, so the read-then-clear never races another eat.
    assign accept = (state_q == ST_RUN) && pos_valid_i
                    && (pac_x_i[3:0] == 4'd8) && (pac_y_i[3:0] == 4'd8)
                    && (eat_tx <= TX_LAST) && (eat_ty <= TY_LAST)
                    && !s1_vld_q && !s2_vld_q;

    assign eat_hit  = s2_vld_q && s2_bit_q && !restart_i;
    assign init_bit = (sw_tx_q != 6'd0) && (sw_tx_q <= TX_MAX)
                      && (sw_ty_q != 5'd0) && (sw_ty_q <= TY_MAX);

    always_comb begin
        state_d   = state_q;
        sw_addr_d = sw_addr_q;
        sw_tx_d   = sw_tx_q;
        sw_ty_d   = sw_ty_q;
        score_d   = score_q;
        left_d    = left_q;
        mem_we    = 1'b0;
        mem_wa    = sw_addr_q;
        mem_wd    = 1'b0;
        s1_vld_d  = accept;
        s1_addr_d = accept ? eat_addr : s1_addr_q;
        s2_vld_d  = s1_vld_q;
        s2_addr_d = s1_addr_q;
        s2_bit_d  = mem_q[s1_addr_q];
        rd_d      = (state_q != ST_INIT) && rd_ok && mem_q[rd_addr];

        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                mem_wa = sw_addr_q;
                mem_wd = init_bit;
                if (sw_addr_q == ADDR_LAST) begin
                    state_d = ST_RUN;
                    left_d  = 11'(PELLETS);
                end else begin
                    sw_addr_d = sw_addr_q + 1'b1;
                    if (sw_tx_q == TX_LAST) begin
                        sw_tx_d = 6'd0;
                        sw_ty_d = sw_ty_q + 5'd1;
                    end else begin
                        sw_tx_d = sw_tx_q + 6'd1;
                    end
                end
            end
            ST_RUN: begin
                if (eat_hit) begin
                    mem_we  = 1'b1;
                    mem_wa  = s2_addr_q;
                    mem_wd  = 1'b0;
                    score_d = bcd_inc(score_q);
                    left_d  = left_q - 11'd1;
                    if (left_q == 11'd1) begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (restart_i) begin
            state_d   = ST_INIT;
            sw_addr_d = '0;
            sw_tx_d   = 6'd0;
            sw_ty_d   = 5'd0;
            s1_vld_d  = 1'b0;
            s2_vld_d  = 1'b0;
            mem_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            sw_addr_q <= '0;
            sw_tx_q   <= 6'd0;
            sw_ty_q   <= 5'd0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_bit_q  <= 1'b0;
            s2_addr_q <= '0;
            score_q   <= 16'h0000;
            left_q    <= 11'd0;
            rd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_addr_q <= sw_addr_d;
            sw_tx_q   <= sw_tx_d;
            sw_ty_q   <= sw_ty_d;
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            s2_vld_q  <= s2_vld_d;
            s2_bit_q  <= s2_bit_d;
            s2_addr_q <= s2_addr_d;
            score_q   <= score_d;
            left_q    <= left_d;
            rd_q      <= rd_d;
        end
    end

    // Map contents need no reset: every reset lands in the sweep, which rewrites all cells.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign rd_pellet_o    = rd_q;
    assign score_bcd_o    = score_q;
    assign pellets_left_o = left_q;
    assign eat_pulse_o    = eat_hit && !rst;
    assign busy_o         = (state_q == ST_INIT);
    assign level_clear_o  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_pellet_tracker.sv
// Scoreboard bench for pellet_tracker: stimulus pushes expected eats, a monitor pops them on eat_pulse.
module tb_pellet_tracker;

    localparam int COLS = 40;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  pac_x = '0;
    logic [8:0]  pac_y = '0;
    logic        pos_valid = 1'b0;
    logic        restart = 1'b0;
    logic [5:0]  rd_tx = '0;
    logic [4:0]  rd_ty = '0;
    logic        rd_pellet;
    logic [15:0] score_bcd;
    logic [10:0] pellets_left;
    logic        eat_pulse;
    logic        busy;
    logic        level_clear;

    pellet_tracker #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk           (clk),
        .rst           (rst),
        .pac_x_i       (pac_x),
        .pac_y_i       (pac_y),
        .pos_valid_i   (pos_valid),
        .restart_i     (restart),
        .rd_tx_i       (rd_tx),
        .rd_ty_i       (rd_ty),
        .rd_pellet_o   (rd_pellet),
        .score_bcd_o   (score_bcd),
        .pellets_left_o(pellets_left),
        .eat_pulse_o   (eat_pulse),
        .busy_o        (busy),
        .level_clear_o (level_clear)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int cyc;
        int score;
        int left;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    bit   mon_pend = 1'b0;

    bit model_p [COLS][ROWS];
    int m_score = 0;
    int m_left  = 0;
    bit m_clear = 1'b0;

    function automatic int to_bcd(int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every eat_pulse must match a queued eat, two cycles after issue; totals checked next cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_pend) begin
                check("eat_score", int'(score_bcd), to_bcd(mon_e.score));
                check("eat_left", int'(pellets_left), mon_e.left);
                mon_pend = 1'b0;
            end
            if (eat_pulse) begin
                check("pulse_queued", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    check("pulse_latency", cyc - mon_e.cyc, 2);
                    mon_pend = 1'b1;
                end
            end
        end
    end

    task automatic model_refill();
        for (int x = 0; x < COLS; x++)
            for (int y = 0; y < ROWS; y++)
                model_p[x][y] = (x >= 1 && x <= COLS - 2 && y >= 1 && y <= ROWS - 2);
        m_left  = (COLS - 2) * (ROWS - 2);
        m_clear = 1'b0;
    endtask

    // Called at the negedge right after the edge that entered INIT, strobes already low.
    task automatic wait_init(string nm);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check(nm, n, 1200);
        model_refill();
    endtask

    task automatic do_restart(string nm);
        pos_valid = 1'b0;
        restart   = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        wait_init(nm);
    endtask

    task automatic eat_px(int x, int y);
        int tx, ty;
        tx = x / 16;
        ty = y / 16;
        pac_x     = 10'(x);
        pac_y     = 9'(y);
        pos_valid = 1'b1;
        if (!m_clear && (x % 16 == 8) && (y % 16 == 8) && tx < COLS && ty < ROWS) begin
            if (model_p[tx][ty]) begin
                model_p[tx][ty] = 1'b0;
                m_score = (m_score < 9999) ? m_score + 1 : 9999;
                m_left--;
                q.push_back('{cyc: cyc, score: m_score, left: m_left});
                if (m_left == 0) m_clear = 1'b1;
            end
        end
        @(negedge clk);
        pos_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic eat_tile(int tx, int ty);
        eat_px(tx * 16 + 8, ty * 16 + 8);
    endtask

    task automatic read_chk(string nm, int tx, int ty, int exp);
        rd_tx = 6'(tx);
        rd_ty = 5'(ty);
        @(negedge clk);
        check(nm, int'(rd_pellet), exp);
    endtask

    task automatic eat_level();
        for (int ty = 1; ty <= ROWS - 2; ty++)
            for (int tx = 1; tx <= COLS - 2; tx++)
                eat_tile(tx, ty);
    endtask

    initial begin
        @(negedge clk);
        check("rst_busy", int'(busy), 1);
        check("rst_score", int'(score_bcd), 0);
        check("rst_left", int'(pellets_left), 0);
        check("rst_pulse", int'(eat_pulse), 0);
        check("rst_rd", int'(rd_pellet), 0);
        check("rst_clear", int'(level_clear), 0);
        rst = 1'b0;
        wait_init("init_cycles");

        check("init_left", int'(pellets_left), 1064);
        check("init_score", int'(score_bcd), 16'h0000);
        check("init_clear", int'(level_clear), 0);
        read_chk("rd_0_0", 0, 0, 0);
        read_chk("rd_1_1", 1, 1, 1);
        read_chk("rd_38_28", 38, 28, 1);
        read_chk("rd_39_29", 39, 29, 0);
        read_chk("rd_oob_x", 45, 3, 0);
        read_chk("rd_oob_y", 5, 31, 0);

        eat_px(24, 24);
        read_chk("rd_1_1_eaten", 1, 1, 0);
        eat_px(24, 24);
        check("repeat_score", int'(score_bcd), 16'h0001);
        check("repeat_left", int'(pellets_left), 1063);

        eat_px(25, 24);
        eat_px(24, 23);
        eat_px(8, 8);
        eat_px(648, 40);
        eat_px(40, 504);
        check("ignored_score", int'(score_bcd), 16'h0001);
        check("ignored_left", int'(pellets_left), 1063);
        check("ignored_queue", q.size(), 0);

        rd_tx = 6'd3;
        rd_ty = 5'd1;
        eat_tile(2, 1);
        check("rd_during_eat", int'(rd_pellet), 1);
        read_chk("rd_2_1_eaten", 2, 1, 0);

        eat_level();
        @(negedge clk);
        check("clr_level", int'(level_clear), 1);
        check("clr_busy", int'(busy), 0);
        check("clr_left", int'(pellets_left), 0);
        check("clr_score", int'(score_bcd), 16'h1064);
        check("clr_queue", q.size(), 0);
        eat_px(24, 24);
        check("clr_hold", int'(level_clear), 1);
        check("clr_hold_score", int'(score_bcd), 16'h1064);

        do_restart("restart_cycles");
        check("rs_left", int'(pellets_left), 1064);
        check("rs_score", int'(score_bcd), 16'h1064);
        check("rs_clear", int'(level_clear), 0);

        pac_x     = 10'd24;
        pac_y     = 9'd24;
        pos_valid = 1'b1;
        @(negedge clk);
        pos_valid = 1'b0;
        restart   = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("abort_busy", int'(busy), 1);
        check("abort_pulse", int'(eat_pulse), 0);
        wait_init("abort_init");
        check("abort_score", int'(score_bcd), 16'h1064);
        check("abort_left", int'(pellets_left), 1064);
        read_chk("abort_rd_1_1", 1, 1, 1);

        m_score = 1064;
        for (int lv = 0; lv < 8; lv++) begin
            eat_level();
            do_restart("lvl_init");
        end
        check("lvl_score", int'(score_bcd), 16'h9576);

        for (int k = 0; k < 423; k++)
            eat_tile(1 + (k % 38), 1 + (k / 38));
        check("sat_pre", int'(score_bcd), 16'h9999);
        eat_tile(1, 20);
        @(negedge clk);
        check("sat_score", int'(score_bcd), 16'h9999);
        check("sat_left", int'(pellets_left), 1064 - 424);
        check("sat_queue", q.size(), 0);

        rst       = 1'b1;
        restart   = 1'b1;
        pac_x     = 10'd40;
        pac_y     = 9'd24;
        pos_valid = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        restart   = 1'b0;
        pos_valid = 1'b0;
        m_score   = 0;
        check("rst2_score", int'(score_bcd), 0);
        check("rst2_left", int'(pellets_left), 0);
        check("rst2_pulse", int'(eat_pulse), 0);
        check("rst2_busy", int'(busy), 1);
        check("rst2_clear", int'(level_clear), 0);
        check("rst2_rd", int'(rd_pellet), 0);
        wait_init("rst2_init");
        check("rst2_left_run", int'(pellets_left), 1064);
        check("final_queue", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
